// File: rtl/axis_loop_genchk.sv
// axis_loop_genchk: per-lane AXI4-Stream loopback FIFO or LFSR frame generator/checker
module axis_loop_genchk #(
    parameter int          DATA_WIDTH    = 32,
    parameter int          FIFO_DEPTH    = 16,
    parameter int          FRAME_LEN     = 16,
    parameter int          ERR_CNT_WIDTH = 8,
    parameter logic [15:0] LFSR_SEED     = 16'hABCD
) (
    input  logic                          USER_CLK,
    input  logic                          RESET_N,
    input  logic                          CHANNEL_UP,
    input  logic                          MODE,
    input  logic                          AXI4_S_IP_TREADY,
    output logic [DATA_WIDTH-1:0]         AXI4_S_OP_TDATA,
    output logic [DATA_WIDTH/8-1:0]       AXI4_S_OP_TKEEP,
    output logic                          AXI4_S_OP_TLAST,
    output logic                          AXI4_S_OP_TVALID,
    input  logic [DATA_WIDTH-1:0]         AXI4_S_IP_TX_TDATA,
    input  logic [DATA_WIDTH/8-1:0]       AXI4_S_IP_TX_TKEEP,
    input  logic                          AXI4_S_IP_TX_TLAST,
    input  logic                          AXI4_S_IP_TX_TVALID,
    output logic [ERR_CNT_WIDTH-1:0]      ERR_COUNT,
    output logic                          OVERFLOW,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);
    localparam int KW = DATA_WIDTH / 8;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = DATA_WIDTH + KW + 1;
    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

    typedef enum logic {IDLE, SEND} state_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[4] ^ s[3] ^ s[2]};
    endfunction

    state_t state;
    logic up_q, mode_q, mode_cur, lb, gc;
    logic [15:0] gen_lfsr, chk_lfsr;
    logic [CW-1:0] gen_cnt, chk_cnt;
    logic [BW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic fifo_empty, fifo_full, push_req, push, pop, tx_valid, chk_err;
    logic [BW-1:0] tx_beat;

    assign mode_cur   = (CHANNEL_UP && !up_q) ? MODE : mode_q;
    assign lb         = CHANNEL_UP && !mode_cur;
    assign gc         = CHANNEL_UP && mode_cur;
    assign fifo_empty = FIFO_LEVEL == '0;
    assign fifo_full  = FIFO_LEVEL == (AW+1)'(FIFO_DEPTH);
    assign pop        = lb && !fifo_empty && AXI4_S_IP_TREADY;
    assign push_req   = lb && AXI4_S_IP_TX_TVALID;
    assign push       = push_req && (!fifo_full || pop);
    assign chk_err    = AXI4_S_IP_TX_TDATA != {(DATA_WIDTH/16){chk_lfsr}} ||
                        AXI4_S_IP_TX_TLAST != (chk_cnt == LAST_CNT) ||
                        AXI4_S_IP_TX_TKEEP != '1;
    assign tx_valid   = mode_q ? state == SEND : !fifo_empty;
    assign tx_beat    = mode_q ? {{(DATA_WIDTH/16){gen_lfsr}}, {KW{1'b1}}, gen_cnt == LAST_CNT} : mem[rd_ptr];
    assign AXI4_S_OP_TVALID = tx_valid;
    assign {AXI4_S_OP_TDATA, AXI4_S_OP_TKEEP, AXI4_S_OP_TLAST} = tx_valid ? tx_beat : '0;

    always_ff @(posedge USER_CLK)
        if (push) mem[wr_ptr] <= {AXI4_S_IP_TX_TDATA, AXI4_S_IP_TX_TKEEP, AXI4_S_IP_TX_TLAST};

    always_ff @(posedge USER_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            up_q       <= 1'b0;
            mode_q     <= 1'b0;
            gen_lfsr   <= LFSR_SEED;
            chk_lfsr   <= LFSR_SEED;
            gen_cnt    <= '0;
            chk_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            FIFO_LEVEL <= '0;
            ERR_COUNT  <= '0;
            OVERFLOW   <= 1'b0;
        end else begin
            up_q     <= CHANNEL_UP;
            mode_q   <= mode_cur;
            OVERFLOW <= OVERFLOW || (push_req && fifo_full && !pop);
            if (gc && AXI4_S_IP_TX_TVALID && chk_err && ERR_COUNT != '1)
                ERR_COUNT <= ERR_COUNT + ERR_CNT_WIDTH'(1);
            if (!CHANNEL_UP) begin
                state      <= IDLE;
                gen_lfsr   <= LFSR_SEED;
                chk_lfsr   <= LFSR_SEED;
                gen_cnt    <= '0;
                chk_cnt    <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                FIFO_LEVEL <= '0;
            end else begin
                wr_ptr     <= wr_ptr + AW'(push);
                rd_ptr     <= rd_ptr + AW'(pop);
                FIFO_LEVEL <= FIFO_LEVEL + (AW+1)'(push) - (AW+1)'(pop);
                if (mode_cur) state <= SEND;
                if (state == SEND && AXI4_S_IP_TREADY) begin
                    gen_lfsr <= lfsr_step(gen_lfsr);
                    gen_cnt  <= gen_cnt == LAST_CNT ? '0 : gen_cnt + CW'(1);
                end
                if (gc && AXI4_S_IP_TX_TVALID) begin
                    chk_lfsr <= lfsr_step(chk_lfsr);
                    chk_cnt  <= chk_cnt == LAST_CNT ? '0 : chk_cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_axis_loop_genchk.sv
// tb_axis_loop_genchk: scoreboard bench for loopback, generate and check modes
module tb_axis_loop_genchk;
    localparam int DW = 32, KW = 4, FD = 4, FL = 4, EW = 8;

    logic clk = 1'b0, rst_n = 1'b0, chan_up = 1'b0, mode = 1'b0, tready = 1'b0;
    logic [DW-1:0] tx_data, rx_data, drv_data = '0;
    logic [KW-1:0] tx_keep, rx_keep, drv_keep = '0;
    logic tx_last, tx_valid, rx_last, rx_valid, drv_last = 1'b0, drv_valid = 1'b0;
    logic [EW-1:0] err_count;
    logic overflow;
    logic [2:0] fifo_level;
    logic loop_en = 1'b0, flip = 1'b0, inv_last = 1'b0, mon_en = 1'b0;
    logic [DW+KW:0] q[$];
    int tests = 0, fails = 0;

    assign rx_data  = loop_en ? tx_data ^ DW'(flip) : drv_data;
    assign rx_keep  = loop_en ? tx_keep : drv_keep;
    assign rx_last  = loop_en ? tx_last ^ inv_last : drv_last;
    assign rx_valid = loop_en ? tx_valid && tready : drv_valid;

    always #5 clk = ~clk;

    axis_loop_genchk #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .FRAME_LEN(FL), .ERR_CNT_WIDTH(EW)) dut (
        .USER_CLK(clk), .RESET_N(rst_n), .CHANNEL_UP(chan_up), .MODE(mode),
        .AXI4_S_IP_TREADY(tready),
        .AXI4_S_OP_TDATA(tx_data), .AXI4_S_OP_TKEEP(tx_keep),
        .AXI4_S_OP_TLAST(tx_last), .AXI4_S_OP_TVALID(tx_valid),
        .AXI4_S_IP_TX_TDATA(rx_data), .AXI4_S_IP_TX_TKEEP(rx_keep),
        .AXI4_S_IP_TX_TLAST(rx_last), .AXI4_S_IP_TX_TVALID(rx_valid),
        .ERR_COUNT(err_count), .OVERFLOW(overflow), .FIFO_LEVEL(fifo_level)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[4] ^ s[3] ^ s[2]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_gen(input int n);
        logic [15:0] s = 16'hABCD;
        for (int i = 0; i < n; i++) begin
            q.push_back({{2{s}}, 4'hF, i % FL == FL - 1});
            s = lfsr_next(s);
        end
    endtask

    task automatic rx(input logic [31:0] d, input logic [3:0] k, input logic l, input logic exp);
        drv_data = d;
        drv_keep = k;
        drv_last = l;
        drv_valid = 1'b1;
        if (exp) q.push_back({d, k, l});
        tick(1);
    endtask

    initial forever begin
        @(negedge clk);
        if (mon_en && tx_valid) begin
            if (q.size() == 0) begin
                if (tready) begin
                    tests++;
                    fails++;
                    $display("FAIL tx unexpected beat: got %0h with empty scoreboard", {tx_data, tx_keep, tx_last});
                end
            end else begin
                chk("tx beat", 64'({tx_data, tx_keep, tx_last}), 64'(q[0]));
                if (tready) void'(q.pop_front());
            end
        end
    end

    initial begin
        tick(2);
        chk("reset outputs", 64'({tx_data, tx_keep, tx_last, tx_valid, err_count, overflow, fifo_level}), 64'd0);
        rst_n = 1'b1;
        tick(1);

        chan_up = 1'b1; mode = 1'b0; tready = 1'b1; mon_en = 1'b1;
        tick(1);
        rx(32'h11111111, 4'hF, 1'b0, 1'b1);
        chk("lb latency tvalid", 64'(tx_valid), 64'd1);
        chk("lb level beat1", 64'(fifo_level), 64'd1);
        rx(32'h22222222, 4'hF, 1'b0, 1'b1);
        chk("lb level beat2", 64'(fifo_level), 64'd1);
        rx(32'h33333333, 4'h3, 1'b1, 1'b1);
        chk("lb level beat3", 64'(fifo_level), 64'd1);
        drv_valid = 1'b0;
        tick(1);
        chk("lb drained level", 64'(fifo_level), 64'd0);
        chk("lb overflow clear", 64'(overflow), 64'd0);
        chk("lb frame all out", 64'(q.size()), 64'd0);

        tready = 1'b0;
        rx(32'hA1A1A1A1, 4'hF, 1'b0, 1'b1);
        rx(32'hA2A2A2A2, 4'hF, 1'b0, 1'b1);
        rx(32'hA3A3A3A3, 4'hF, 1'b0, 1'b1);
        rx(32'hA4A4A4A4, 4'hF, 1'b1, 1'b1);
        chk("lb full level", 64'(fifo_level), 64'd4);
        chk("lb full no overflow", 64'(overflow), 64'd0);
        tready = 1'b1;
        rx(32'hA5A5A5A5, 4'hF, 1'b0, 1'b1);
        chk("lb full push+pop level", 64'(fifo_level), 64'd4);
        chk("lb full push+pop overflow", 64'(overflow), 64'd0);
        tready = 1'b0;
        rx(32'hA6A6A6A6, 4'hF, 1'b1, 1'b0);
        chk("lb drop level", 64'(fifo_level), 64'd4);
        chk("lb drop overflow", 64'(overflow), 64'd1);
        drv_valid = 1'b0; tready = 1'b1;
        tick(4);
        chk("lb drain level", 64'(fifo_level), 64'd0);
        chk("lb drain beats", 64'(q.size()), 64'd0);
        tready = 1'b0;
        chk("err held in loopback", 64'(err_count), 64'd0);
        chan_up = 1'b0; mon_en = 1'b0;
        tick(2);
        chk("down overflow sticky", 64'(overflow), 64'd1);
        chk("down tvalid", 64'(tx_valid), 64'd0);

        push_gen(10);
        mode = 1'b1; chan_up = 1'b1; tready = 1'b1; mon_en = 1'b1;
        tick(1);
        chk("gen first beat", 64'(tx_data), 64'h00000000ABCDABCD);
        for (int i = 0; i < 100; i++) begin
            tready = ~tready;
            tick(1);
            chk("gen no gap", 64'(tx_valid), 64'd1);
            if (q.size() == 0) break;
        end
        tready = 1'b0; mon_en = 1'b0;
        chk("gen frames drained", 64'(q.size()), 64'd0);
        chan_up = 1'b0;
        tick(2);

        loop_en = 1'b1; tready = 1'b1; mode = 1'b1; chan_up = 1'b1;
        tick(1000);
        chk("check clean 1000 beats", 64'(err_count), 64'd0);
        flip = 1'b1; tick(1); flip = 1'b0; tick(2);
        chk("err after data flip", 64'(err_count), 64'd1);
        inv_last = 1'b1; tick(1); inv_last = 1'b0; tick(2);
        chk("err after tlast flip", 64'(err_count), 64'd2);

        flip = 1'b1;
        tick(200);
        chk("err count 202", 64'(err_count), 64'd202);
        tick(100);
        chk("err saturates", 64'(err_count), 64'd255);
        tick(20);
        chk("err stays saturated", 64'(err_count), 64'd255);
        flip = 1'b0;

        loop_en = 1'b0; chan_up = 1'b0;
        tick(2);
        push_gen(3);
        mode = 1'b1; chan_up = 1'b1; tready = 1'b1; mon_en = 1'b1;
        tick(1);
        mode = 1'b0;
        tick(2);
        chan_up = 1'b0;
        tick(1);
        chk("drop tvalid next cycle", 64'(tx_valid), 64'd0);
        tready = 1'b0; mon_en = 1'b0;
        chk("beats before drop", 64'(q.size()), 64'd0);
        chk("drop fifo level", 64'(fifo_level), 64'd0);
        chk("drop err retained", 64'(err_count), 64'd255);
        push_gen(5);
        mode = 1'b1; chan_up = 1'b1; tready = 1'b1; mon_en = 1'b1;
        tick(6);
        tready = 1'b0; mon_en = 1'b0;
        chk("reup restarted frame", 64'(q.size()), 64'd0);
        chk("reup fifo level", 64'(fifo_level), 64'd0);
        chk("reup err retained", 64'(err_count), 64'd255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axis_loop_genchk.md
Name: axis_loop_genchk

Overview:
Parametrised per-lane AXI4-Stream traffic engine for the Aurora user interface, one instance per lane.
- It takes over both roles currently filled by separate blocks: the frame generator/checker and the loopback buffer.
- The role is selected at run time by MODE.
- It adds generic data width, a configurable loopback FIFO depth and frame length, overflow detection, a saturating error counter, and clean abort/resync on channel drop.
- It sits between the Aurora core TX/RX user ports and the user-status registers in the lane top level.

Parameters:
DATA_WIDTH, 32, TX/RX data width in bits; multiple of 16.
FIFO_DEPTH, 16, loopback FIFO depth in beats; power of 2, at least 4.
FRAME_LEN, 16, generator frame length in beats; at least 1.
ERR_CNT_WIDTH, 8, error counter width.
LFSR_SEED, 16'hABCD, generator/checker LFSR seed; must be non-zero.

Ports:
USER_CLK  in  1  core user clock; all logic on rising edge.
RESET_N  in  1  asynchronous, active-low reset.
CHANNEL_UP  in  1  Aurora channel up.
MODE  in  1  0 = loopback, 1 = generate/check; latched on CHANNEL_UP rising edge.
AXI4_S_IP_TREADY  in  1  TX ready from core.
AXI4_S_OP_TDATA  out  DATA_WIDTH  TX data.
AXI4_S_OP_TKEEP  out  DATA_WIDTH/8  TX byte keep.
AXI4_S_OP_TLAST  out  1  TX end of frame.
AXI4_S_OP_TVALID  out  1  TX valid.
AXI4_S_IP_TX_TDATA  in  DATA_WIDTH  RX data (no backpressure).
AXI4_S_IP_TX_TKEEP  in  DATA_WIDTH/8  RX keep.
AXI4_S_IP_TX_TLAST  in  1  RX end of frame.
AXI4_S_IP_TX_TVALID  in  1  RX valid.
ERR_COUNT  out  ERR_CNT_WIDTH  checker error count, saturating.
OVERFLOW  out  1  sticky: loopback beat dropped.
FIFO_LEVEL  out  log2(FIFO_DEPTH)+1  loopback FIFO occupancy.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - All outputs are 0 and the FIFO is empty.
  - Generator and checker LFSRs load LFSR_SEED; beat counters are 0; FSM is IDLE; the latched mode is 0.
- Mode latch: a registered copy of MODE is captured on the cycle CHANNEL_UP goes 0 to 1. MODE changes while CHANNEL_UP=1 are ignored.
- LFSR: 16-bit Fibonacci, x^16+x^5+x^4+x^3+1. Beat data is the current LFSR state replicated DATA_WIDTH/16 times.
- CHANNEL_UP low (including mid-frame):
  - TVALID drops the next cycle; the FSM goes to IDLE.
  - LFSRs reload the seed, beat counters clear, and the FIFO flushes (level 0).
  - ERR_COUNT and OVERFLOW are retained; only reset clears them.
- Loopback (latched mode 0, CHANNEL_UP=1):
  - The FIFO is first-word-fall-through, storing {TDATA, TKEEP, TLAST}.
  - Each RX beat with TVALID=1 is pushed. TX presents the FIFO head with TVALID = not empty; a pop occurs on TVALID&TREADY.
  - Latency: an RX beat in cycle N into an empty FIFO gives TVALID=1 in cycle N+1.
  - Full with push and no pop: the beat is dropped and OVERFLOW is set.
  - Full with push and pop in the same cycle: both proceed, the level stays at FIFO_DEPTH, no overflow.
  - Empty with push and pop: impossible, since TVALID=0 when empty.
  - FIFO_LEVEL is exact every cycle.
- Generate (latched mode 1):
  - FSM IDLE to SEND when CHANNEL_UP=1.
  - In SEND, TVALID=1 and TKEEP is all ones. TDATA and TLAST are held stable until TREADY.
  - On each handshake the generator LFSR steps and the beat counter increments. TLAST=1 when the counter is FRAME_LEN-1, then the counter wraps to 0.
  - Frames are sent back-to-back with no gap cycle. The LFSR runs continuously across frames.
- Check (latched mode 1): on each RX valid beat, compare against the checker LFSR and the checker beat count.
  - Error if TDATA differs from the expected replicated LFSR.
  - Error if TLAST differs from (count == FRAME_LEN-1).
  - Error if TKEEP is not all ones.
  - At most one error is counted per beat. ERR_COUNT increments by 1 and saturates at all ones without wrap.
  - The checker LFSR and count advance on every valid beat regardless of error, so there is no resync except on channel drop.
- In loopback mode the checker is idle and ERR_COUNT holds.
- FRAME_LEN=1: every beat carries TLAST.

Test Plan:
1. Loopback, DATA_WIDTH=32, FIFO_DEPTH=4, TREADY=1. Inject 3-beat frame 0x11111111/0x22222222/0x33333333 with TLAST on beat 3 -> identical TX beats 1 cycle later, same TKEEP/TLAST, FIFO_LEVEL peaks at 1, OVERFLOW=0.
2. Loopback, TREADY=0, inject 5 beats -> FIFO_LEVEL=4, OVERFLOW=1, 5th beat lost. Then TREADY=1 -> exactly beats 1-4 out. Also: full with push+pop -> level stays 4, OVERFLOW does not newly set.
3. Gen mode, FRAME_LEN=4, CHANNEL_UP=1, TREADY toggling 1/0 -> first beat TDATA=32'hABCDABCD held through stalls, TLAST on every 4th accepted beat, no gap between frames.
4. Gen/check with TX looped to RX -> ERR_COUNT=0 after 1000 beats. Flip bit 0 of one RX beat -> ERR_COUNT=1. Force a TLAST on beat 2 -> ERR_COUNT=2.
5. ERR_CNT_WIDTH=8, corrupt 300 beats -> ERR_COUNT=255, stays 255.
6. Drop CHANNEL_UP mid-frame (beat 2 of 4) and toggle MODE while up -> TVALID low next cycle, mode unchanged. On re-up, first beat is the seed pattern with count restarted, FIFO_LEVEL=0, and ERR_COUNT is preserved.
